spi_shift_engine: RTL
=====================

Name: spi_shift_engine

Overview:
Byte-level SPI mode-0 master engine that sits directly downstream of the 68000 bus/register interface of the SD SPI controller. It accepts one byte plus a latched speed code per transfer, generates sclk from the single system clock, shifts the byte out on mosi, and captures 8 bits from miso. A one-deep pending slot lets the bus side issue the next byte while the current byte is still shifting. Chip-select generation stays in the bus interface.

Parameters:
DIV_SLOW, 16, half-period of sclk in cck cycles for speed code 00 (sclk = cck/32)
DIV_MID, 4, half-period for speed code 01 (sclk = cck/8)
DIV_TURBO, 1, half-period for speed codes 10 and 11 (sclk = cck/2)

Ports:
cck  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
speed  input  2  speed code; sampled only when a byte is accepted
start  input  1  single-cycle request to transfer tx_data
tx_data  input  8  byte to transmit, MSB first
ready  output  1  high when start will be accepted (pending slot empty)
busy  output  1  high while a byte is shifting or a byte is pending
rx_data  output  8  last completed received byte; held until next completion
done  output  1  one-cycle pulse when rx_data is updated
sclk  output  1  SPI clock, idle low (CPOL=0, CPHA=0)
mosi  output  1  SPI data out, idle high
miso  input  1  SPI data in

Behaviour:
- Reset (async, any time incl. mid-byte): state IDLE, sclk=0, mosi=1, rx_data=8'h00, done=0, busy=0, ready=1, pending slot cleared, bit counter and divider cleared. Partial rx bits are discarded.
- States: IDLE, SHIFT, DONE.
- Accept rule: start=1 with ready=1 at a cck edge. In IDLE the byte loads into the shift register, speed is latched into the half-period H, and the state goes to SHIFT. In SHIFT or DONE the byte and speed go to the pending slot, and ready drops to 0 on the next cycle. start with ready=0 is ignored, and the pending contents are unchanged.
- SHIFT entry: sclk=0 and mosi=tx[7] on the same edge. The divider counts H cycles per half-period.
- Each low half-period ends with sclk rising. Each high half-period ends with sclk falling. At that same edge, miso is shifted into rx bit 0 (MSB-first capture) and mosi moves to the next tx bit.
- After the 8th falling edge the state goes to DONE. mosi returns to 1 unless a pending byte is loaded.
- DONE lasts exactly one cycle: done=1 and rx_data updates on the edge entering DONE. If the pending slot is full, the next edge loads it, enters SHIFT, and frees the slot (ready=1). Otherwise the state goes to IDLE.
- Latency: from the accept edge to the edge asserting done is 16*H + 1 cycles. That is 17 for turbo and 257 for slow. Back-to-back bytes add 1 cycle (the DONE cycle) of sclk-low gap.
- Simultaneous start in DONE with an empty pending slot: the byte is captured into pending and starts on the next edge exactly as above. It must not be dropped.
- speed changes mid-byte have no effect until the next accept. Codes 10 and 11 are identical.
- busy = (state != IDLE) or pending full. ready = not pending full.
- sclk and mosi are registered outputs with no combinational path from inputs.

Test Plan:
- Turbo read: speed=10, tx=8'hFF, miso pattern 8'hDE (bit changes on sclk falling edge) -> mosi stays 1 for all 8 rising edges, done at accept+17 cycles, rx_data=8'hDE, 8 sclk pulses of 1 cck high each.
- Slow write: speed=00, tx=8'hA5 -> bits sampled on sclk rising edges read 1,0,1,0,0,1,0,1, each sclk half-period is 16 cck, done at accept+257, mosi=1 afterwards.
- Back-to-back queueing: speed=01, issue 8'h12 then 8'h34 while busy, then 8'h56 while ready=0 -> 8'h56 ignored, mosi stream 12 34 only, done pulses 66 cycles apart, ready returns 1 the cycle after the first DONE.
- Start in DONE cycle: turbo, second start coincides with done=1 -> second byte transfers and its done follows 18 cycles after the first.
- Reset mid-transfer: assert reset after 3 sclk rising edges -> sclk=0, mosi=1, busy=0, rx_data=00, ready=1 immediately (asynchronously). A new byte after release completes normally.
- Speed change mid-byte: speed 00 to 10 during a slow byte -> remaining half-periods stay 16 cycles. The next accepted byte runs at 1-cycle half-periods.

Source files
------------

// File: rtl/spi_shift_engine.sv
// ---------------------------------------------------------------------------
// spi_shift_engine
//   Byte-level SPI mode-0 master (CPOL=0, CPHA=0). One byte plus a speed code
//   is accepted per transfer. sclk is derived from cck with a per-byte
//   half-period H, the byte is shifted out MSB first on mosi, and 8 bits are
//   captured from miso. A one-deep pending slot lets the next byte be queued
//   while the current one is still shifting.
//
// Ports
//   cck      in   system clock, all state changes on the rising edge
//   reset    in   asynchronous active-high reset
//   speed    in   [1:0] speed code, sampled only when a byte is accepted
//   start    in   single-cycle transfer request for tx_data
//   tx_data  in   [7:0] byte to transmit, MSB first
//   ready    out  start will be accepted (pending slot empty)
//   busy     out  byte shifting, in its done cycle, or a byte pending
//   rx_data  out  [7:0] last completed received byte
//   done     out  one-cycle pulse when rx_data updates
//   sclk     out  SPI clock, idle low
//   mosi     out  SPI data out, idle high
//   miso     in   SPI data in
// ---------------------------------------------------------------------------
module spi_shift_engine #(
  parameter int unsigned DIV_SLOW  = 16,
  parameter int unsigned DIV_MID   = 4,
  parameter int unsigned DIV_TURBO = 1
) (
  input  logic       cck,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  // Divider width sized for the slowest (largest) half-period.
  localparam int unsigned DIV_W = $clog2(DIV_SLOW + 1);
  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Datapath registers
  logic [7:0]       tx_sh_q,     tx_sh_d;
  logic [7:0]       rx_sh_q,     rx_sh_d;
  logic [DIV_W-1:0] half_q,      half_d;
  logic [DIV_W-1:0] div_q,       div_d;
  logic [BIT_W-1:0] bit_q,       bit_d;
  logic             tail_q,      tail_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic [DIV_W-1:0] pend_half_q, pend_half_d;
  logic             sclk_q,      sclk_d;
  logic             mosi_q,      mosi_d;
  logic [7:0]       rx_data_q,   rx_data_d;
  logic             done_q,      done_d;
  logic             ready_q,     ready_d;
  logic             busy_q,      busy_d;

  // Byte-load selection (fresh request or pending slot)
  logic             load;
  logic [7:0]       load_data;
  logic [DIV_W-1:0] load_half;

  logic accept;
  logic half_end;

  // Speed code to sclk half-period in cck cycles; codes 10 and 11 alias.
  function automatic logic [DIV_W-1:0] half_of(input logic [1:0] code);
    case (code)
      2'b00:   half_of = DIV_W'(DIV_SLOW);
      2'b01:   half_of = DIV_W'(DIV_MID);
      default: half_of = DIV_W'(DIV_TURBO);
    endcase
  endfunction

  assign accept   = start && ready_q;
  assign half_end = (div_q == (half_q - DIV_W'(1)));

  // State register
  always_ff @(posedge cck or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The tail flag marks the one cycle after the 8th
  // falling edge, which gives the 16*H+1 accept-to-done latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (tail_q) state_d = DONE;
      DONE:    state_d = (pend_full_q || accept) ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    half_d      = half_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tail_d      = tail_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    pend_half_d = pend_half_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rx_data_d   = rx_data_q;
    done_d      = 1'b0;
    load        = 1'b0;
    load_data   = tx_data;
    load_half   = half_of(speed);

    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end

      SHIFT: begin
        // Queue the next byte while this one shifts.
        if (accept) begin
          pend_full_d = 1'b1;
          pend_data_d = tx_data;
          pend_half_d = half_of(speed);
        end
        if (tail_q) begin
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
        end else if (half_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // End of a high half-period: capture miso, advance mosi. Ones
          // are shifted in behind the data so mosi idles high afterwards.
          if (sclk_q) begin
            rx_sh_d = {rx_sh_q[6:0], miso};
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[6:0], 1'b1};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(7)) tail_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      DONE: begin
        // A request arriving in this cycle with an empty slot is loaded
        // directly, so it starts on the same edge a queued byte would.
        if (pend_full_q) begin
          load        = 1'b1;
          load_data   = pend_data_q;
          load_half   = pend_half_q;
          pend_full_d = 1'b0;
        end else if (accept) begin
          load = 1'b1;
        end
      end

      default: ;
    endcase

    if (load) begin
      tx_sh_d = load_data;
      rx_sh_d = '0;
      half_d  = load_half;
      div_d   = '0;
      bit_d   = '0;
      tail_d  = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = load_data[7];
    end

    ready_d = !pend_full_d;
    busy_d  = (state_d != IDLE) || pend_full_d;
  end

  // Datapath registers
  always_ff @(posedge cck or posedge reset) begin
    if (reset) begin
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      half_q      <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      tail_q      <= 1'b0;
      pend_full_q <= 1'b0;
      pend_data_q <= '0;
      pend_half_q <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      half_q      <= half_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tail_q      <= tail_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      pend_half_q <= pend_half_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule
